// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl: round-robin scan controller for a SAR ADC core.
// Walks the enabled channels in CH_MASK. For each channel it settles the
// analog mux, requests a conversion and captures the result. A conversion
// that never completes is abandoned and flagged in TIMEOUT_ERR.
// Optional build macro SAR_SCAN_AVG_EN: convert each channel four times and
// report the truncated mean. Leave the macro undefined for one conversion
// per channel.
module sar_scan_ctrl #(
    parameter int NBITS   = 5,
    parameter int NCH     = 4,
    parameter int TIMEOUT = 64,
    parameter int SETTLE  = 2,
    localparam int CW     = $clog2(NCH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [NCH-1:0]   CH_MASK,
    output logic             ADC_GO,
    input  logic             ADC_VALID,
    input  logic [NBITS-1:0] ADC_RESULT,
    output logic [CW-1:0]    CH_SEL,
    output logic [NBITS-1:0] DATA,
    output logic [CW-1:0]    DATA_CH,
    output logic             DATA_VLD,
    output logic             BUSY,
    output logic             TIMEOUT_ERR,
    input  logic             ERR_CLR
);

    // One counter serves both the settle wait and the conversion timeout.
    localparam int TW = $clog2(((TIMEOUT > SETTLE) ? TIMEOUT : SETTLE) + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] ST_LAST = TW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CONVERT,
        S_CAPTURE,
        S_RELEASE
    } state_t;

    state_t          state;
    logic [TW-1:0]   cnt;

`ifdef SAR_SCAN_AVG_EN
    logic [NBITS+1:0] acc_p0;
    logic [1:0]       avg_idx;

    // Mean of four samples: drop the two fraction bits (truncation).
    function automatic logic [NBITS-1:0] avg4(input logic [NBITS+1:0] sum);
        return sum[NBITS+1:2];
    endfunction
`else
    logic [NBITS-1:0] res_p0;
`endif

    // Lowest enabled channel above cur, otherwise the lowest enabled channel.
    function automatic logic [CW-1:0] next_ch(input logic [CW-1:0]  cur,
                                              input logic [NCH-1:0] mask);
        logic [CW-1:0] first;
        logic [CW-1:0] above;
        logic          hit_first;
        logic          hit_above;
        first     = '0;
        above     = '0;
        hit_first = 1'b0;
        hit_above = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (mask[i] && !hit_first) begin
                first     = CW'(i);
                hit_first = 1'b1;
            end
            if (mask[i] && !hit_above && (i > int'(cur))) begin
                above     = CW'(i);
                hit_above = 1'b1;
            end
        end
        return hit_above ? above : first;
    endfunction

    // Scan FSM with registered outputs. The mask is read only when a channel
    // is chosen, so it may change freely while a conversion is in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ADC_GO      <= 1'b0;
            CH_SEL      <= CW'(NCH - 1);
            DATA        <= '0;
            DATA_CH     <= '0;
            DATA_VLD    <= 1'b0;
            BUSY        <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
`ifdef SAR_SCAN_AVG_EN
            acc_p0      <= '0;
            avg_idx     <= '0;
`else
            res_p0      <= '0;
`endif
        end else begin
            DATA_VLD <= 1'b0;
            // A timeout set later in this block overrides the clear.
            if (ERR_CLR)
                TIMEOUT_ERR <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (EN && (|CH_MASK)) begin
                        state  <= S_SETTLE;
                        CH_SEL <= next_ch(CH_SEL, CH_MASK);
                        cnt    <= '0;
                        BUSY   <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == ST_LAST) begin
                        state  <= S_CONVERT;
                        cnt    <= '0;
                        ADC_GO <= 1'b1;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                S_CONVERT: begin
                    if (ADC_VALID) begin
                        state  <= S_CAPTURE;
                        ADC_GO <= 1'b0;
`ifdef SAR_SCAN_AVG_EN
                        acc_p0 <= ((avg_idx == 2'd0) ? '0 : acc_p0)
                                  + {2'b00, ADC_RESULT};
`else
                        res_p0 <= ADC_RESULT;
`endif
                    end else if (cnt == TO_LAST) begin
                        state       <= S_RELEASE;
                        cnt         <= '0;
                        ADC_GO      <= 1'b0;
                        TIMEOUT_ERR <= 1'b1;
`ifdef SAR_SCAN_AVG_EN
                        avg_idx     <= '0;
`endif
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                S_CAPTURE: begin
                    state <= S_RELEASE;
`ifdef SAR_SCAN_AVG_EN
                    if (avg_idx == 2'd3) begin
                        DATA     <= avg4(acc_p0);
                        DATA_CH  <= CH_SEL;
                        DATA_VLD <= 1'b1;
                        avg_idx  <= '0;
                    end else begin
                        avg_idx <= avg_idx + 2'd1;
                    end
`else
                    DATA     <= res_p0;
                    DATA_CH  <= CH_SEL;
                    DATA_VLD <= 1'b1;
`endif
                end
                S_RELEASE: begin
                    cnt <= '0;
`ifdef SAR_SCAN_AVG_EN
                    if (avg_idx != 2'd0) begin
                        state  <= S_CONVERT;
                        ADC_GO <= 1'b1;
                    end else
`endif
                    if (EN && (|CH_MASK)) begin
                        state  <= S_SETTLE;
                        CH_SEL <= next_ch(CH_SEL, CH_MASK);
                    end else begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    ADC_GO <= 1'b0;
                    BUSY   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// tb_sar_scan_ctrl: directed bench for sar_scan_ctrl with a behavioural
// SAR core model and a scoreboard of expected (channel, data) results.
module tb_sar_scan_ctrl;

    localparam int NBITS   = 5;
    localparam int NCH     = 4;
    localparam int TIMEOUT = 64;
    localparam int SETTLE  = 2;
    localparam int CW      = $clog2(NCH);
`ifdef SAR_SCAN_AVG_EN
    localparam int NAVG = 4;
`else
    localparam int NAVG = 1;
`endif

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             en         = 1'b0;
    logic [NCH-1:0]   ch_mask    = '0;
    logic             adc_valid  = 1'b0;
    logic [NBITS-1:0] adc_result = '0;
    logic             err_clr    = 1'b0;
    logic             adc_go;
    logic [CW-1:0]    ch_sel;
    logic [NBITS-1:0] data;
    logic [CW-1:0]    data_ch;
    logic             data_vld;
    logic             busy;
    logic             timeout_err;

    sar_scan_ctrl #(
        .NBITS  (NBITS),
        .NCH    (NCH),
        .TIMEOUT(TIMEOUT),
        .SETTLE (SETTLE)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .EN         (en),
        .CH_MASK    (ch_mask),
        .ADC_GO     (adc_go),
        .ADC_VALID  (adc_valid),
        .ADC_RESULT (adc_result),
        .CH_SEL     (ch_sel),
        .DATA       (data),
        .DATA_CH    (data_ch),
        .DATA_VLD   (data_vld),
        .BUSY       (busy),
        .TIMEOUT_ERR(timeout_err),
        .ERR_CLR    (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // SAR model controls, written by the stimulus process only
    int sar_lat = 7;       // VALID on the Nth cycle of GO high; 0 = never
    bit use_tab = 1'b0;    // results from res_tab instead of ch*3
    int res_tab [4] = '{5, 6, 6, 7};

    // model state, owned by the compare process
    int  go_len      = 0;
    bit  valid_given = 1'b0;
    bit  prev_go     = 1'b0;
    bit  prev_vld    = 1'b0;
    int  last_ch     = NCH - 1;
    int  exp_ch      = 0;
    int  avg_n       = 0;
    int  acc         = 0;
    int  exp_q_ch   [$];
    int  exp_q_data [$];
    int  log_ch     [$];
    int  log_data   [$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scan order rule: next enabled channel after cur, wrapping around.
    function automatic int next_enabled(input int cur, input logic [NCH-1:0] m);
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (cur + k) % NCH;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    // Compare process plus SAR core model, evaluated on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                go_len      = 0;
                valid_given = 1'b0;
                prev_go     = 1'b0;
                prev_vld    = 1'b0;
                last_ch     = NCH - 1;
                avg_n       = 0;
                acc         = 0;
                exp_q_ch.delete();
                exp_q_data.delete();
                adc_valid   = 1'b0;
            end else begin
                if (data_vld) begin
                    chk("vld_single_cycle", int'(prev_vld), 0);
                    log_ch.push_back(int'(data_ch));
                    log_data.push_back(int'(data));
                    if (exp_q_ch.size() == 0) begin
                        chk("vld_unexpected", 1, 0);
                    end else begin
                        chk("data_ch", int'(data_ch), exp_q_ch.pop_front());
                        chk("data", int'(data), exp_q_data.pop_front());
                    end
                end
                if (adc_go)
                    chk("busy_during_go", int'(busy), 1);
                if (adc_go && !prev_go) begin
                    exp_ch = (avg_n == 0) ? next_enabled(last_ch, ch_mask) : last_ch;
                    chk("ch_sel_at_go", int'(ch_sel), exp_ch);
                    last_ch     = exp_ch;
                    go_len      = 0;
                    valid_given = 1'b0;
                end
                if (adc_go)
                    go_len++;
                if (!adc_go && prev_go) begin
                    if (valid_given) begin
                        chk("go_len_valid", go_len, sar_lat);
                    end else begin
                        chk("go_len_timeout", go_len, TIMEOUT);
                        chk("timeout_err_set", int'(timeout_err), 1);
                        avg_n = 0;
                        acc   = 0;
                    end
                end
                adc_valid = 1'b0;
                if (adc_go && !valid_given && sar_lat != 0 && go_len == sar_lat) begin
                    int r;
                    r = use_tab ? res_tab[avg_n] : int'(ch_sel) * 3;
                    adc_valid   = 1'b1;
                    adc_result  = NBITS'(r);
                    valid_given = 1'b1;
                    acc += r;
                    avg_n++;
                    if (avg_n == NAVG) begin
                        exp_q_ch.push_back(int'(ch_sel));
                        exp_q_data.push_back(acc / NAVG);
                        avg_n = 0;
                        acc   = 0;
                    end
                end
                prev_go  = adc_go;
                prev_vld = data_vld;
            end
        end
    end

    task automatic wait_go_fall(input string name);
        int c;
        c = 0;
        while (!adc_go && c < 300) begin @(negedge clk); c++; end
        while (adc_go && c < 300) begin @(negedge clk); c++; end
        chk(name, int'(c < 300), 1);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int c;
        c = 0;
        while (busy && c < limit) begin @(negedge clk); c++; end
        chk(name, int'(busy), 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_go"},       int'(adc_go), 0);
        chk({tag, "_ch_sel"},   int'(ch_sel), NCH - 1);
        chk({tag, "_data"},     int'(data), 0);
        chk({tag, "_data_ch"},  int'(data_ch), 0);
        chk({tag, "_data_vld"}, int'(data_vld), 0);
        chk({tag, "_busy"},     int'(busy), 0);
        chk({tag, "_terr"},     int'(timeout_err), 0);
    endtask

    initial begin
        int cyc;
        int n_before;
        int saw_busy;
        int saw_go;

        // reset held for 10 cycles
        rst     = 1'b1;
        en      = 1'b0;
        ch_mask = 4'b0101;
        sar_lat = 7;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_scan_without_en", int'(busy), 0);

        // basic scan of channels 0 and 2, result = ch*3
        en  = 1'b1;
        cyc = 0;
        while (!data_vld && cyc < 200) begin @(negedge clk); cyc++; end
`ifndef SAR_SCAN_AVG_EN
        chk("first_vld_latency", cyc, 11);
`endif
        cyc = 0;
        while (log_ch.size() < 3 && cyc < 400) begin @(negedge clk); cyc++; end
        en = 1'b0;
        wait_idle("scan_stop_idle", 400);
        chk("scan_vld_count", int'(log_ch.size() >= 3), 1);
        if (log_ch.size() >= 3) begin
            chk("scan0_ch", log_ch[0], 0);
            chk("scan0_data", log_data[0], 0);
            chk("scan1_ch", log_ch[1], 2);
            chk("scan1_data", log_data[1], 6);
            chk("scan2_ch", log_ch[2], 0);
            chk("scan2_data", log_data[2], 0);
        end
        chk("scan_queue_drained", exp_q_ch.size(), 0);

        // empty mask: controller must stay idle
        ch_mask  = 4'b0000;
        en       = 1'b1;
        saw_busy = 0;
        saw_go   = 0;
        repeat (20) begin
            @(negedge clk);
            saw_busy |= int'(busy);
            saw_go   |= int'(adc_go);
        end
        chk("mask0_busy", saw_busy, 0);
        chk("mask0_go", saw_go, 0);
        en = 1'b0;

        // timeout with ERR_CLR held: set wins, then clears next cycle
        ch_mask  = 4'b0100;
        sar_lat  = 0;
        err_clr  = 1'b1;
        n_before = log_ch.size();
        en       = 1'b1;
        wait_go_fall("timeout1_done");
        @(negedge clk);
        chk("err_clr_next_cycle", int'(timeout_err), 0);
        err_clr = 1'b0;
        // second timeout on the same channel, flag stays sticky
        wait_go_fall("timeout2_done");
        en = 1'b0;
        wait_idle("timeout_idle", 100);
        chk("timeout_err_sticky", int'(timeout_err), 1);
        chk("timeout_no_vld", log_ch.size(), n_before);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("timeout_err_cleared", int'(timeout_err), 0);

        // EN dropped two cycles into CONVERT: result still delivered
        ch_mask  = 4'b0110;
        sar_lat  = 7;
        n_before = log_ch.size();
        en       = 1'b1;
        cyc      = 0;
        while (!adc_go && cyc < 50) begin @(negedge clk); cyc++; end
        repeat (2) @(negedge clk);
        en  = 1'b0;
        cyc = 0;
        while (!data_vld && cyc < 200) begin @(negedge clk); cyc++; end
        chk("en_drop_vld_seen", int'(data_vld), 1);
        @(negedge clk);
        chk("en_drop_busy_low", int'(busy), 0);
        chk("en_drop_vld_count", log_ch.size(), n_before + 1);
        if (log_ch.size() > n_before) begin
            chk("en_drop_ch", log_ch[n_before], 1);
            chk("en_drop_data", log_data[n_before], 3);
        end

        // asynchronous reset in the middle of CONVERT
        ch_mask = 4'b1000;
        sar_lat = 0;
        en      = 1'b1;
        cyc     = 0;
        while (!adc_go && cyc < 50) begin @(negedge clk); cyc++; end
        repeat (3) @(negedge clk);
        chk("pre_reset_go_high", int'(adc_go), 1);
        #2 rst = 1'b1;
        #1 check_reset_values("async_rst");
        en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_go", int'(adc_go), 0);

`ifdef SAR_SCAN_AVG_EN
        // four-sample averaging: 5,6,6,7 -> 24>>2 = 6
        ch_mask  = 4'b0001;
        sar_lat  = 7;
        use_tab  = 1'b1;
        n_before = log_ch.size();
        en       = 1'b1;
        cyc      = 0;
        while (!data_vld && cyc < 300) begin @(negedge clk); cyc++; end
        en = 1'b0;
        chk("avg_data", int'(data), 6);
        chk("avg_ch", int'(data_ch), 0);
        wait_idle("avg_idle", 200);
        chk("avg_single_vld", log_ch.size(), n_before + 1);
        use_tab = 1'b0;
`endif

        chk("final_queue_empty", exp_q_ch.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
